// File: rtl/pe_fpbp_feeder.sv
// Upstream feeder for the 3-weight dual-input PE: weight capture, activation FIFO and row
// sequencer. Define PE_FEED_STAT_EN to add the stall_cnt statistics output.
module pe_fpbp_feeder #(
   parameter int unsigned N          = 8,
   parameter int unsigned ROW_LEN    = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DRAIN_CYC  = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         w_load,
   input  logic [N-1:0] w_in0,
   input  logic [N-1:0] w_in1,
   input  logic [N-1:0] w_in2,
   input  logic         start,
   input  logic         mode,
   input  logic         act_valid,
   output logic         act_ready,
   input  logic [N-1:0] act_data0,
   input  logic [N-1:0] act_data1,
   output logic [N-1:0] i0,
   output logic [N-1:0] i1,
   output logic [N-1:0] w0,
   output logic [N-1:0] w1,
   output logic [N-1:0] w2,
   output logic         select0,
   output logic         select1,
   output logic         pe_valid,
   output logic         busy,
   output logic         done,
`ifdef PE_FEED_STAT_EN
   output logic [15:0]  stall_cnt,
`endif
   output logic         underflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(ROW_LEN + 1);
   localparam int unsigned DrnW = $clog2(DRAIN_CYC + 1);
   localparam logic [PtrW:0]   FifoFull  = (PtrW + 1)'(FIFO_DEPTH);
   localparam logic [CntW-1:0] LastBeat  = CntW'(ROW_LEN - 1);
   localparam logic [DrnW-1:0] DrainLast = DrnW'(DRAIN_CYC);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e          state_q;
   logic [CntW-1:0] issue_cnt_q;
   logic [DrnW-1:0] drain_cnt_q;

   logic [N-1:0]    mem0_q [FIFO_DEPTH];
   logic [N-1:0]    mem1_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   level_q;
   logic            fifo_empty, push, pop;

   assign fifo_empty = (level_q == '0);
   assign act_ready  = (level_q != FifoFull);
   assign push       = act_valid && act_ready;
   assign pop        = (state_q == StRun) && !fifo_empty;
   assign busy       = (state_q != StIdle);

   // Storage needs no reset; emptiness is tracked by level_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem0_q[wr_ptr_q] <= act_data0;
         mem1_q[wr_ptr_q] <= act_data1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop) level_q <= level_q + 1'b1;
         else if (!push && pop) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         issue_cnt_q <= '0;
         drain_cnt_q <= '0;
         i0          <= '0;
         i1          <= '0;
         w0          <= '0;
         w1          <= '0;
         w2          <= '0;
         select0     <= 1'b0;
         select1     <= 1'b0;
         pe_valid    <= 1'b0;
         done        <= 1'b0;
         underflow   <= 1'b0;
`ifdef PE_FEED_STAT_EN
         stall_cnt   <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (w_load) begin
                  w0 <= w_in0;
                  w1 <= w_in1;
                  w2 <= w_in2;
               end
               if (start) begin
                  state_q     <= StRun;
                  issue_cnt_q <= '0;
                  select0     <= mode;
                  select1     <= ~mode;
                  underflow   <= 1'b0;
`ifdef PE_FEED_STAT_EN
                  stall_cnt   <= '0;
`endif
               end
            end
            StRun: begin
               if (pop) begin
                  i0          <= mem0_q[rd_ptr_q];
                  i1          <= mem1_q[rd_ptr_q];
                  pe_valid    <= 1'b1;
                  issue_cnt_q <= issue_cnt_q + 1'b1;
                  if (issue_cnt_q == LastBeat) begin
                     state_q     <= StDrain;
                     drain_cnt_q <= '0;
                  end
               end else begin
                  i0        <= '0;
                  i1        <= '0;
                  pe_valid  <= 1'b0;
                  underflow <= 1'b1;
`ifdef PE_FEED_STAT_EN
                  if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
               end
            end
            StDrain: begin
               // The first drain edge retires the last real beat, so DRAIN_CYC zero beats
               // are visible before done.
               i0       <= '0;
               i1       <= '0;
               pe_valid <= 1'b0;
               if (drain_cnt_q == DrainLast) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 1'b1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_fpbp_feeder.sv
// Self-checking bench for pe_fpbp_feeder: directed row scenarios with randomized data,
// checked every cycle against a queue-based behavioural model.
module tb_pe_fpbp_feeder;

   localparam int N          = 8;
   localparam int ROW_LEN    = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int DRAIN_CYC  = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         w_load = 1'b0, start = 1'b0, mode = 1'b0, act_valid = 1'b0;
   logic [N-1:0] w_in0 = '0, w_in1 = '0, w_in2 = '0, act_data0 = '0, act_data1 = '0;
   logic         act_ready, select0, select1, pe_valid, busy, done, underflow;
   logic [N-1:0] i0, i1, w0, w1, w2;
`ifdef PE_FEED_STAT_EN
   logic [15:0]  stall_cnt;
`endif

   pe_fpbp_feeder #(
      .N(N), .ROW_LEN(ROW_LEN), .FIFO_DEPTH(FIFO_DEPTH), .DRAIN_CYC(DRAIN_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .w_load(w_load),
      .w_in0(w_in0), .w_in1(w_in1), .w_in2(w_in2),
      .start(start), .mode(mode), .act_valid(act_valid), .act_ready(act_ready),
      .act_data0(act_data0), .act_data1(act_data1), .i0(i0), .i1(i1),
      .w0(w0), .w1(w1), .w2(w2), .select0(select0), .select1(select1),
      .pe_valid(pe_valid), .busy(busy), .done(done),
`ifdef PE_FEED_STAT_EN
      .stall_cnt(stall_cnt),
`endif
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Behavioural model: queue of {data1,data0}, phase 0 idle / 1 run / 2 drain / 3 done.
   logic [2*N-1:0] q [$];
   int             m_phase, beats, drain_left, stalls;
   logic [N-1:0]   e_i0, e_i1, e_w0, e_w1, e_w2;
   logic           e_pv, e_s0, e_s1, e_done, e_uf;
   int             vectors = 0, miscompares = 0;
   int             next_k, push_left, pat;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_phase = 0; beats = 0; drain_left = 0; stalls = 0;
      e_i0 = '0; e_i1 = '0; e_w0 = '0; e_w1 = '0; e_w2 = '0;
      e_pv = 0; e_s0 = 0; e_s1 = 0; e_done = 0; e_uf = 0;
   endtask

   task automatic compare_all(string p);
      check({p, "_i0"}, i0, e_i0);
      check({p, "_i1"}, i1, e_i1);
      check({p, "_w0"}, w0, e_w0);
      check({p, "_w1"}, w1, e_w1);
      check({p, "_w2"}, w2, e_w2);
      check({p, "_pe_valid"}, pe_valid, e_pv);
      check({p, "_select0"}, select0, e_s0);
      check({p, "_select1"}, select1, e_s1);
      check({p, "_done"}, done, e_done);
      check({p, "_underflow"}, underflow, e_uf);
      check({p, "_busy"}, busy, m_phase != 0);
      check({p, "_act_ready"}, act_ready, q.size() < FIFO_DEPTH);
`ifdef PE_FEED_STAT_EN
      check({p, "_stall_cnt"}, stall_cnt, (stalls > 65535) ? 65535 : stalls);
`endif
   endtask

   // Apply current inputs for one clock, advance the model, then compare after the edge.
   task automatic tick();
      logic           do_push, nonempty;
      logic [2*N-1:0] head;
      do_push  = act_valid && (q.size() < FIFO_DEPTH);
      nonempty = q.size() > 0;
      head     = nonempty ? q[0] : '0;
      e_done   = 0;
      case (m_phase)
         0: begin
            if (w_load) begin e_w0 = w_in0; e_w1 = w_in1; e_w2 = w_in2; end
            if (start) begin
               m_phase = 1; beats = 0; stalls = 0; e_uf = 0; e_s0 = mode; e_s1 = !mode;
            end
         end
         1: begin
            if (nonempty) begin
               void'(q.pop_front());
               e_i0 = head[N-1:0]; e_i1 = head[2*N-1:N]; e_pv = 1; beats++;
               if (beats == ROW_LEN) begin m_phase = 2; drain_left = DRAIN_CYC; end
            end else begin
               e_i0 = '0; e_i1 = '0; e_pv = 0; e_uf = 1; stalls++;
            end
         end
         2: begin
            e_i0 = '0; e_i1 = '0; e_pv = 0;
            if (drain_left == 0) begin m_phase = 3; e_done = 1; end
            else drain_left--;
         end
         default: m_phase = 0;
      endcase
      if (do_push) begin
         q.push_back({act_data1, act_data0});
         push_left--; next_k++;
      end
      @(posedge clk); #1;
      compare_all("cyc");
   endtask

   task automatic drive_beat(int gap_pct);
      if (push_left > 0 && int'($urandom_range(99)) >= gap_pct) begin
         act_valid = 1'b1;
         case (pat)
            0:       begin act_data0 = N'(next_k); act_data1 = N'($urandom); end
            1:       begin act_data0 = N'(next_k); act_data1 = N'(100 + next_k); end
            default: begin act_data0 = N'($urandom); act_data1 = N'($urandom); end
         endcase
      end else begin
         act_valid = 1'b0;
      end
      tick();
   endtask

   task automatic start_row(logic m, int gap_pct);
      start = 1'b1; mode = m;
      drive_beat(gap_pct);
      start = 1'b0;
   endtask

   task automatic finish_row(int gap_pct, string tag);
      int budget = 400;
      while (m_phase != 0 && budget > 0) begin
         drive_beat(gap_pct);
         budget--;
      end
      act_valid = 1'b0;
      check({tag, "_row_ended"}, busy, 1'b0);
   endtask

   task automatic new_stream(int k, int p, int n);
      next_k = k; pat = p; push_left = n;
   endtask

   initial begin
      logic [N-1:0] nw0, nw1, nw2;
      model_reset();
      #12;
      compare_all("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Conv row: weights 1,2,3, pre-fill four beats, then stream 1..16 with no gaps.
      w_load = 1'b1; w_in0 = 8'd1; w_in1 = 8'd2; w_in2 = 8'd3;
      tick();
      w_load = 1'b0;
      new_stream(1, 0, ROW_LEN);
      repeat (4) drive_beat(0);
      check("conv_prefill_full", act_ready, 1'b0);
      start_row(1'b0, 0);
      check("conv_select1", select1, 1'b1);
      finish_row(0, "conv");
      check("conv_underflow", underflow, 1'b0);

      // Dual row: pairs (k, 100+k).
      new_stream(int'($urandom_range(1, 100)), 1, ROW_LEN);
      repeat (2) drive_beat(0);
      start_row(1'b1, 0);
      check("dual_select0", select0, 1'b1);
      finish_row(0, "dual");

      // Underflow: empty FIFO at start, first beat pushed three RUN cycles later.
      new_stream(0, 2, ROW_LEN);
      act_valid = 1'b0;
      start = 1'b1; mode = 1'b0; tick(); start = 1'b0;
      repeat (2) tick();
      finish_row(0, "uflow");
      check("uflow_sticky", underflow, 1'b1);
`ifdef PE_FEED_STAT_EN
      check("uflow_stall_cnt", stall_cnt, 16'd3);
`endif

      // Reset in the middle of a row, then a normal row with random gaps.
      new_stream(0, 2, ROW_LEN);
      repeat (2) drive_beat(0);
      start_row(1'b1, 0);
      repeat (5) drive_beat(0);
      act_valid = 1'b0;
      reset_n = 1'b0; #2;
      model_reset();
      compare_all("midreset");
      @(posedge clk); #1;
      compare_all("midreset_edge");
      reset_n = 1'b1;
      new_stream(0, 2, ROW_LEN);
      repeat (2) drive_beat(0);
      start_row(1'b0, 30);
      finish_row(30, "postreset");

      // Backpressure: act_valid held in IDLE, only FIFO_DEPTH beats accepted.
      new_stream(0, 2, ROW_LEN);
      repeat (7) drive_beat(0);
      check("bp_ready_low", act_ready, 1'b0);
      check("bp_not_busy", busy, 1'b0);
      start_row(1'($urandom_range(1)), 0);
      finish_row(0, "bp");

      // Ignored controls during RUN, then w_load+start together in IDLE.
      nw0 = 8'd5; nw1 = 8'd6; nw2 = 8'd7;
      w_load = 1'b1; w_in0 = nw0; w_in1 = nw1; w_in2 = nw2;
      tick();
      w_load = 1'b0;
      new_stream(0, 2, ROW_LEN);
      repeat (2) drive_beat(0);
      start_row(1'b0, 0);
      w_load = 1'b1; w_in0 = 8'd9; w_in1 = 8'd9; w_in2 = 8'd9;
      start = 1'b1; mode = 1'b1;
      repeat (3) drive_beat(10);
      w_load = 1'b0; start = 1'b0;
      check("ign_w0", w0, nw0);
      check("ign_w2", w2, nw2);
      check("ign_select0", select0, 1'b0);
      finish_row(10, "ign");
      nw0 = N'($urandom); nw1 = N'($urandom); nw2 = N'($urandom);
      new_stream(0, 2, ROW_LEN);
      repeat (2) drive_beat(0);
      w_load = 1'b1; w_in0 = nw0; w_in1 = nw1; w_in2 = nw2;
      start_row(1'b1, 0);
      w_load = 1'b0;
      check("wstart_w0", w0, nw0);
      check("wstart_w1", w1, nw1);
      finish_row(20, "wstart");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
